// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core.
//   sw_state_e   - control FSM states
//   bcd_digit_t  - one 4-bit BCD digit
//   sw_time_t    - mm:ss.cc as six BCD digits, [23:20] = minute tens, [3:0] = cc ones
//   DIGIT_MOD    - per-digit modulus, index 0 = cc ones
//   bcd_time_inc - adds one centisecond; returns {carry_out, next_time}
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StLap
  } sw_state_e;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [23:0] sw_time_t;

  localparam bcd_digit_t MOD_CC_ONES  = 4'd10;
  localparam bcd_digit_t MOD_CC_TENS  = 4'd10;
  localparam bcd_digit_t MOD_SEC_ONES = 4'd10;
  localparam bcd_digit_t MOD_SEC_TENS = 4'd6;
  localparam bcd_digit_t MOD_MIN_ONES = 4'd10;
  localparam bcd_digit_t MOD_MIN_TENS = 4'd6;

  // Packed so that DIGIT_MOD[i] lines up with digit i of sw_time_t.
  localparam logic [5:0][3:0] DIGIT_MOD = {MOD_MIN_TENS, MOD_MIN_ONES, MOD_SEC_TENS,
                                           MOD_SEC_ONES, MOD_CC_TENS, MOD_CC_ONES};

  localparam sw_time_t TIME_ZERO = 24'h000000;

  // Ripple carry through all six digits in one evaluation. Carry out of the top
  // digit only happens at 59:59.99, where every digit sits at its maximum.
  function automatic logic [24:0] bcd_time_inc(input sw_time_t t);
    sw_time_t   r;
    logic       c;
    bcd_digit_t d;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = r[i*4 +: 4];
      if (c) begin
        if (d == DIGIT_MOD[i] - 4'd1) begin
          d = 4'd0;
        end else begin
          d = d + 4'd1;
          c = 1'b0;
        end
      end
      r[i*4 +: 4] = d;
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronizer and edge detector for the asynchronous 10 ms tick toggle.
//   i_clk      - system clock
//   i_rst_n    - asynchronous active-low reset
//   i_tick     - asynchronous toggle input
//   o_tick_evt - single-cycle increment event
// The event is decoded from flop outputs only, so it is high for exactly the
// cycle after the synchronized level changes.
module tick_edge_sync #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          TICK_BOTH_EDGES = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  output logic o_tick_evt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_tick};
      r_prev <= w_sync_out;
    end
  end

  always_comb begin
    if (TICK_BOTH_EDGES) begin
      o_tick_evt = w_sync_out ^ r_prev;
    end else begin
      o_tick_evt = w_sync_out & ~r_prev;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: counts 10 ms ticks as mm:ss.cc BCD with run/pause/lap/clear control.
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   tick_in    - asynchronous 10 ms toggle timebase
//   start_stop - command pulse: start or stop counting
//   clear      - command pulse: zero the count (PAUSE) or the overflow flag (IDLE)
//   lap        - command pulse: freeze / unfreeze the display while counting continues
//   time_bcd   - displayed time, six BCD digits
//   running    - high in RUN and LAP
//   lap_hold   - high in LAP
//   wrap       - one-cycle pulse on 59:59.99 -> 00:00.00
//   overflow   - sticky rollover flag
// All outputs are registered from the same next-state values as the internal
// state, so they change on the same edge as the live count.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          TICK_BOTH_EDGES = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic        lap_hold,
  output logic        wrap,
  output logic        overflow
);

  sw_state_e r_state;
  sw_time_t  r_count;
  sw_time_t  r_lap;
  sw_time_t  r_time_bcd;
  logic      r_running;
  logic      r_lap_hold;
  logic      r_wrap;
  logic      r_overflow;

  sw_state_e   w_state_next;
  sw_time_t    w_count_next;
  sw_time_t    w_lap_next;
  logic        w_wrap_next;
  logic        w_ovf_next;
  logic        w_tick_evt;
  logic        w_inc_en;
  logic [24:0] w_inc;

  tick_edge_sync #(
    .SYNC_STAGES     (SYNC_STAGES),
    .TICK_BOTH_EDGES (TICK_BOTH_EDGES)
  ) u_tick_edge_sync (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_tick     (tick_in),
    .o_tick_evt (w_tick_evt)
  );

  assign w_inc    = bcd_time_inc(r_count);
  assign w_inc_en = w_tick_evt && ((r_state == StRun) || (r_state == StLap));

  // Increment is decided from the current state, so a tick coinciding with
  // RUN->PAUSE is applied and one coinciding with PAUSE->RUN is dropped.
  // Lap capture uses r_count, i.e. the pre-increment value.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_lap_next   = r_lap;
    w_wrap_next  = 1'b0;
    w_ovf_next   = r_overflow;

    if (w_inc_en) begin
      w_count_next = w_inc[23:0];
      if (w_inc[24]) begin
        w_wrap_next = 1'b1;
        w_ovf_next  = 1'b1;
      end
    end

    // Highest-priority pulse wins; lower-priority pulses that cycle are dropped.
    if (clear) begin
      case (r_state)
        StPause: begin
          w_state_next = StIdle;
          w_count_next = TIME_ZERO;
          w_lap_next   = TIME_ZERO;
          w_ovf_next   = 1'b0;
        end
        StIdle:  w_ovf_next = 1'b0;
        default: ;
      endcase
    end else if (start_stop) begin
      case (r_state)
        StIdle:  w_state_next = StRun;
        StRun:   w_state_next = StPause;
        StLap:   w_state_next = StPause;
        StPause: w_state_next = StRun;
        default: w_state_next = StIdle;
      endcase
    end else if (lap) begin
      case (r_state)
        StRun: begin
          w_state_next = StLap;
          w_lap_next   = r_count;
        end
        StLap:   w_state_next = StRun;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_count    <= TIME_ZERO;
      r_lap      <= TIME_ZERO;
      r_time_bcd <= TIME_ZERO;
      r_running  <= 1'b0;
      r_lap_hold <= 1'b0;
      r_wrap     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_lap      <= w_lap_next;
      r_time_bcd <= (w_state_next == StLap) ? w_lap_next : w_count_next;
      r_running  <= (w_state_next == StRun) || (w_state_next == StLap);
      r_lap_hold <= (w_state_next == StLap);
      r_wrap     <= w_wrap_next;
      r_overflow <= w_ovf_next;
    end
  end

  assign time_bcd = r_time_bcd;
  assign running  = r_running;
  assign lap_hold = r_lap_hold;
  assign wrap     = r_wrap;
  assign overflow = r_overflow;

endmodule
